// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, stalls memory states on mem_ready, counts
// retired instructions and flags undefined opcodes.
module multicycle_main_control #(
    parameter int unsigned CNT_W    = 16,
    parameter logic [5:0]  OP_RTYPE = 6'h00,
    parameter logic [5:0]  OP_LW    = 6'h23,
    parameter logic [5:0]  OP_SW    = 6'h2B,
    parameter logic [5:0]  OP_BEQ   = 6'h04,
    parameter logic [5:0]  OP_J     = 6'h02,
    parameter logic [5:0]  OP_ADDI  = 6'h08
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             IorD,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic             addi,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUop,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic             instr_retired,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExec     = 4'd6,
        StRComp    = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StAddiExec = 4'd10,
        StAddiWb   = 4'd11
    } state_e;

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;

    // State, illegal-opcode pulse and retire counter; reset wins and aborts any instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    // Next-state decode and retire detection.
    always_comb begin
        state_d   = StFetch;
        illegal_d = 1'b0;
        unique case (state_q)
            StFetch:    state_d = mem_ready ? StDecode : StFetch;
            StDecode: begin
                if (opcode == OP_RTYPE) begin
                    state_d = StExec;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = StMemAddr;
                end else if (opcode == OP_BEQ) begin
                    state_d = StBranch;
                end else if (opcode == OP_J) begin
                    state_d = StJump;
                end else if (opcode == OP_ADDI) begin
                    state_d = StAddiExec;
                end else begin
                    state_d   = StFetch;
                    illegal_d = 1'b1;
                end
            end
            StMemAddr: begin
                if (opcode == OP_LW) begin
                    state_d = StMemRead;
                end else if (opcode == OP_SW) begin
                    state_d = StMemWrite;
                end else begin
                    state_d = StFetch;
                end
            end
            StMemRead:  state_d = mem_ready ? StMemWb : StMemRead;
            StMemWrite: state_d = mem_ready ? StFetch : StMemWrite;
            StExec:     state_d = StRComp;
            StAddiExec: state_d = StAddiWb;
            default:    state_d = StFetch;
        endcase

        retire = 1'b0;
        unique case (state_q)
            StMemWb, StRComp, StBranch, StJump, StAddiWb: retire = 1'b1;
            StMemWrite: retire = mem_ready;
            default:    retire = 1'b0;
        endcase
        // An instruction caught by reset never retires.
        retire  = retire & rst_n;
        count_d = retire ? count_q + CNT_W'(1) : count_q;
    end

    // Moore output decode; write strobes are masked while reset is asserted.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        IorD        = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        addi        = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUop       = 2'b00;
        unique case (state_q)
            StFetch: begin
                MemRead = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                ALUSrcB = 2'b01;
            end
            StDecode:   ALUSrcB = 2'b11;
            StMemAddr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StMemRead: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            StMemWb: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            StMemWrite: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            StExec: begin
                ALUSrcA = 1'b1;
                ALUop   = 2'b10;
            end
            StRComp: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            StBranch: begin
                ALUSrcA     = 1'b1;
                ALUop       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            StJump: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            StAddiExec: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUop   = 2'b10;
                addi    = 1'b1;
            end
            StAddiWb:   RegWrite = 1'b1;
            default:    ;
        endcase
        if (!rst_n) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            MemWrite    = 1'b0;
            RegWrite    = 1'b0;
        end
    end

    assign state         = state_q;
    assign illegal_op    = illegal_q;
    assign instr_retired = retire;
    assign retire_count  = count_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Table-driven bench for multicycle_main_control, plus hand sequences for
// counter wrap (on a narrow-counter instance) and reset during a store stall.
module tb_multicycle_main_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_ready;

    logic        PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite;
    logic        IorD, MemtoReg, RegDst, ALUSrcA, addi;
    logic [1:0]  ALUSrcB, PCSource, ALUop;
    logic [3:0]  state;
    logic        illegal_op, instr_retired;
    logic [15:0] retire_count;

    // Narrow-counter instance sharing the stimulus, used to observe wrap-around.
    logic        w_pcw, w_pcwc, w_irw, w_mr, w_mw, w_rw, w_iord, w_m2r, w_rd, w_sa, w_addi;
    logic [1:0]  w_sb, w_ps, w_op;
    logic [3:0]  w_state;
    logic        w_ill, w_ret;
    logic [3:0]  w_count;

    always #5 clk = ~clk;

    multicycle_main_control u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IorD(IorD), .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
        .addi(addi), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUop(ALUop),
        .state(state), .illegal_op(illegal_op), .instr_retired(instr_retired),
        .retire_count(retire_count)
    );

    multicycle_main_control #(.CNT_W(4)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(w_pcw), .PCWriteCond(w_pcwc), .IRWrite(w_irw),
        .MemRead(w_mr), .MemWrite(w_mw), .RegWrite(w_rw),
        .IorD(w_iord), .MemtoReg(w_m2r), .RegDst(w_rd), .ALUSrcA(w_sa),
        .addi(w_addi), .ALUSrcB(w_sb), .PCSource(w_ps), .ALUop(w_op),
        .state(w_state), .illegal_op(w_ill), .instr_retired(w_ret),
        .retire_count(w_count)
    );

    // {PCWrite,PCWriteCond,IRWrite,MemRead,MemWrite,RegWrite,IorD,MemtoReg,RegDst,ALUSrcA,addi,
    //  ALUSrcB,PCSource,ALUop}
    logic [16:0] cw;
    assign cw = {PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite, IorD, MemtoReg,
                 RegDst, ALUSrcA, addi, ALUSrcB, PCSource, ALUop};

    localparam logic [16:0] CW_F   = 17'b1_0_1_1_0_0_0_0_0_0_0_01_00_00;
    localparam logic [16:0] CW_FS  = 17'b0_0_0_1_0_0_0_0_0_0_0_01_00_00;
    localparam logic [16:0] CW_DEC = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
    localparam logic [16:0] CW_MA  = 17'b0_0_0_0_0_0_0_0_0_1_0_10_00_00;
    localparam logic [16:0] CW_MR  = 17'b0_0_0_1_0_0_1_0_0_0_0_00_00_00;
    localparam logic [16:0] CW_MWB = 17'b0_0_0_0_0_1_0_1_0_0_0_00_00_00;
    localparam logic [16:0] CW_MW  = 17'b0_0_0_0_1_0_1_0_0_0_0_00_00_00;
    localparam logic [16:0] CW_EX  = 17'b0_0_0_0_0_0_0_0_0_1_0_00_00_10;
    localparam logic [16:0] CW_RC  = 17'b0_0_0_0_0_1_0_0_1_0_0_00_00_00;
    localparam logic [16:0] CW_BR  = 17'b0_1_0_0_0_0_0_0_0_1_0_00_01_01;
    localparam logic [16:0] CW_J   = 17'b1_0_0_0_0_0_0_0_0_0_0_00_10_00;
    localparam logic [16:0] CW_AE  = 17'b0_0_0_0_0_0_0_0_0_1_1_10_00_10;
    localparam logic [16:0] CW_AW  = 17'b0_0_0_0_0_1_0_0_0_0_0_00_00_00;
    // MEMWRITE with reset asserted: MemWrite masked, IorD still decoded.
    localparam logic [16:0] CW_MWR = 17'b0_0_0_0_0_0_1_0_0_0_0_00_00_00;

    typedef struct packed {
        logic        rst_n;
        logic [5:0]  opcode;
        logic        mem_ready;
        logic [3:0]  st;
        logic [16:0] cw;
        logic        ill;
        logic        ret;
        logic [15:0] cnt;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [$];

    initial begin
        // Reset, R-type, lw with 2 stalls, addi, illegal, beq, sw with stalls, jump.
        vecs.push_back('{1'b0, 6'h00, 1'b1, 4'd0,  CW_FS,  1'b0, 1'b0, 16'd0});
        vecs.push_back('{1'b0, 6'h00, 1'b1, 4'd0,  CW_FS,  1'b0, 1'b0, 16'd0});
        vecs.push_back('{1'b0, 6'h00, 1'b1, 4'd0,  CW_FS,  1'b0, 1'b0, 16'd0});
        vecs.push_back('{1'b1, 6'h00, 1'b1, 4'd0,  CW_F,   1'b0, 1'b0, 16'd0});
        vecs.push_back('{1'b1, 6'h00, 1'b1, 4'd1,  CW_DEC, 1'b0, 1'b0, 16'd0});
        vecs.push_back('{1'b1, 6'h00, 1'b1, 4'd6,  CW_EX,  1'b0, 1'b0, 16'd0});
        vecs.push_back('{1'b1, 6'h00, 1'b1, 4'd7,  CW_RC,  1'b0, 1'b1, 16'd0});
        vecs.push_back('{1'b1, 6'h23, 1'b1, 4'd0,  CW_F,   1'b0, 1'b0, 16'd1});
        vecs.push_back('{1'b1, 6'h23, 1'b1, 4'd1,  CW_DEC, 1'b0, 1'b0, 16'd1});
        vecs.push_back('{1'b1, 6'h23, 1'b1, 4'd2,  CW_MA,  1'b0, 1'b0, 16'd1});
        vecs.push_back('{1'b1, 6'h23, 1'b0, 4'd3,  CW_MR,  1'b0, 1'b0, 16'd1});
        vecs.push_back('{1'b1, 6'h23, 1'b0, 4'd3,  CW_MR,  1'b0, 1'b0, 16'd1});
        vecs.push_back('{1'b1, 6'h23, 1'b1, 4'd3,  CW_MR,  1'b0, 1'b0, 16'd1});
        vecs.push_back('{1'b1, 6'h23, 1'b1, 4'd4,  CW_MWB, 1'b0, 1'b1, 16'd1});
        vecs.push_back('{1'b1, 6'h08, 1'b1, 4'd0,  CW_F,   1'b0, 1'b0, 16'd2});
        vecs.push_back('{1'b1, 6'h08, 1'b1, 4'd1,  CW_DEC, 1'b0, 1'b0, 16'd2});
        vecs.push_back('{1'b1, 6'h08, 1'b1, 4'd10, CW_AE,  1'b0, 1'b0, 16'd2});
        vecs.push_back('{1'b1, 6'h08, 1'b1, 4'd11, CW_AW,  1'b0, 1'b1, 16'd2});
        vecs.push_back('{1'b1, 6'h3F, 1'b1, 4'd0,  CW_F,   1'b0, 1'b0, 16'd3});
        vecs.push_back('{1'b1, 6'h3F, 1'b1, 4'd1,  CW_DEC, 1'b0, 1'b0, 16'd3});
        vecs.push_back('{1'b1, 6'h3F, 1'b1, 4'd0,  CW_F,   1'b1, 1'b0, 16'd3});
        vecs.push_back('{1'b1, 6'h04, 1'b1, 4'd1,  CW_DEC, 1'b0, 1'b0, 16'd3});
        vecs.push_back('{1'b1, 6'h04, 1'b1, 4'd8,  CW_BR,  1'b0, 1'b1, 16'd3});
        vecs.push_back('{1'b1, 6'h2B, 1'b0, 4'd0,  CW_FS,  1'b0, 1'b0, 16'd4});
        vecs.push_back('{1'b1, 6'h2B, 1'b1, 4'd0,  CW_F,   1'b0, 1'b0, 16'd4});
        vecs.push_back('{1'b1, 6'h2B, 1'b1, 4'd1,  CW_DEC, 1'b0, 1'b0, 16'd4});
        vecs.push_back('{1'b1, 6'h2B, 1'b1, 4'd2,  CW_MA,  1'b0, 1'b0, 16'd4});
        vecs.push_back('{1'b1, 6'h2B, 1'b0, 4'd5,  CW_MW,  1'b0, 1'b0, 16'd4});
        vecs.push_back('{1'b1, 6'h2B, 1'b1, 4'd5,  CW_MW,  1'b0, 1'b1, 16'd4});
        vecs.push_back('{1'b1, 6'h02, 1'b1, 4'd0,  CW_F,   1'b0, 1'b0, 16'd5});
        vecs.push_back('{1'b1, 6'h02, 1'b1, 4'd1,  CW_DEC, 1'b0, 1'b0, 16'd5});
        vecs.push_back('{1'b1, 6'h02, 1'b1, 4'd9,  CW_J,   1'b0, 1'b1, 16'd5});

        rst_n     = 1'b0;
        opcode    = 6'h00;
        mem_ready = 1'b1;
        step();

        foreach (vecs[i]) begin
            rst_n     = vecs[i].rst_n;
            opcode    = vecs[i].opcode;
            mem_ready = vecs[i].mem_ready;
            #1;
            check($sformatf("v%0d state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("v%0d ctrl", i), 32'(cw), 32'(vecs[i].cw));
            check($sformatf("v%0d illegal_op", i), 32'(illegal_op), 32'(vecs[i].ill));
            check($sformatf("v%0d instr_retired", i), 32'(instr_retired), 32'(vecs[i].ret));
            check($sformatf("v%0d retire_count", i), 32'(retire_count), 32'(vecs[i].cnt));
            step();
        end

        // Counter wrap: jumps take the count from 6 to 16; the 4-bit instance wraps 15 -> 0.
        check("post-table count", 32'(retire_count), 32'd6);
        opcode    = 6'h02;
        mem_ready = 1'b1;
        for (int j = 0; j < 9; j++) begin
            step();
            step();
            step();
        end
        check("count 15", 32'(retire_count), 32'd15);
        check("narrow count all-ones", 32'(w_count), 32'hF);
        step();
        step();
        check("jump retire", 32'(instr_retired), 32'd1);
        step();
        check("count 16", 32'(retire_count), 32'd16);
        check("narrow count wrap", 32'(w_count), 32'd0);
        check("state after jump", 32'(state), 32'd0);

        // Reset while a store waits on memory.
        opcode = 6'h2B;
        step();
        step();
        step();
        mem_ready = 1'b0;
        #1;
        check("sw stall state", 32'(state), 32'd5);
        check("sw stall MemWrite", 32'(MemWrite), 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset MemWrite masked", 32'(MemWrite), 32'd0);
        check("reset ctrl in MEMWRITE", 32'(cw), 32'(CW_MWR));
        check("reset no retire", 32'(instr_retired), 32'd0);
        step();
        check("reset state", 32'(state), 32'd0);
        check("reset count", 32'(retire_count), 32'd0);
        check("reset illegal_op", 32'(illegal_op), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
